// File: rtl/aes_pkg.sv
// Shared AES block/byte types used by the ciphertext packer and its block FIFO.
package aes_pkg;
  localparam int AES_BLK_BYTES = 16;
  localparam int AES_BLK_W     = 128;
  typedef logic [AES_BLK_W-1:0] aes_block_t;
  typedef logic [7:0]           aes_byte_t;
endpackage

// File: rtl/aes_blk_fifo.sv
// Small synchronous FIFO of 128-bit AES blocks; the head entry is presented
// directly from storage so the output carries no combinational input path.
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  aes_block_t din,
  output aes_block_t dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  // Extra MSB on each pointer distinguishes full from empty when indices match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  aes_block_t  mem [FIFO_DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/aes_ct_packer.sv
// Packs the AES core's byte-serial ciphertext into 128-bit blocks (first byte
// in the MSBs) and buffers finished blocks for a stallable valid/ready consumer.
module aes_ct_packer
  import aes_pkg::*;
#(
  parameter int BLK_BYTES  = AES_BLK_BYTES,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  aes_byte_t              in_byte,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   clear,
  output logic [8*BLK_BYTES-1:0] out_block,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             partial_cnt,
  output logic [15:0]            blocks_out
);
  localparam int         W    = 8 * BLK_BYTES;
  localparam logic [3:0] LAST = 4'(BLK_BYTES - 1);

  logic [W-1:0] shreg;
  logic [W-1:0] next_blk;
  logic [15:0]  pop_cnt;
  logic         fifo_full;
  logic         fifo_empty;
  logic         last_byte;
  logic         accept;
  logic         push;
  logic         pop;

  // in_ready only gates the block-completing byte, so it depends on registers alone.
  assign last_byte = (partial_cnt == LAST);
  assign in_ready  = !(last_byte && fifo_full);
  assign accept    = in_valid && in_ready && !clear;
  assign push      = accept && last_byte;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign next_blk  = {shreg[W-9:0], in_byte};
  assign blocks_out = pop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg       <= '0;
      partial_cnt <= '0;
      pop_cnt     <= '0;
    end else begin
      if (clear) begin
        shreg       <= '0;
        partial_cnt <= '0;
      end else if (accept) begin
        shreg       <= next_blk;
        partial_cnt <= last_byte ? 4'd0 : partial_cnt + 4'd1;
      end
      if (pop) pop_cnt <= pop_cnt + 16'd1;
    end
  end

  aes_blk_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (next_blk),
    .dout  (out_block),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_aes_ct_packer.sv
// Directed bench for aes_ct_packer: expected blocks are queued by the stimulus
// and checked by an independent monitor whenever the packer hands a block over.
module tb_aes_ct_packer;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_ready;
  logic         clear;
  logic [127:0] out_block;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   partial_cnt;
  logic [15:0]  blocks_out;

  int n_tests = 0;
  int n_fail  = 0;
  int stalls  = 0;
  logic [127:0] exp_q[$];
  logic [127:0] hold_blk;

  localparam logic [127:0] FIPS_BLK = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BLK_00   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] BLK_10   = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] BLK_20   = 128'h202122232425262728292a2b2c2d2e2f;
  localparam logic [127:0] BLK_AA   = 128'haaabacadaeafb0b1b2b3b4b5b6b7b8b9;
  localparam logic [127:0] BLK_C0   = 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf;
  localparam logic [127:0] BLK_D0   = 128'hd0d1d2d3d4d5d6d7d8d9dadbdcdddedf;

  always #5 clk = ~clk;

  aes_ct_packer #(
    .BLK_BYTES (16),
    .FIFO_DEPTH(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .clear      (clear),
    .out_block  (out_block),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .partial_cnt(partial_cnt),
    .blocks_out (blocks_out)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handshake on the output side must match the next queued block.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_block: got %h, expected none", out_block);
      end else begin
        chk("out_block", out_block, exp_q.pop_front());
      end
    end
  end

  // Presents one byte starting at posedge+1; returns at posedge+1 after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited   = 0;
    in_byte  = b;
    in_valid = 1'b1;
    if (!in_ready) stalls++;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready %b, expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_byte   = 8'h00;
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_block", out_block, 128'd0);
    chk("rst_partial", 128'(partial_cnt), 128'd0);
    chk("rst_blocks_out", 128'(blocks_out), 128'd0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", 128'(in_ready), 128'd1);

    // FIPS-197 ciphertext, consumer always ready
    begin
      logic [127:0] v;
      v = FIPS_BLK;
      out_ready = 1'b1;
      exp_q.push_back(FIPS_BLK);
      for (int i = 15; i >= 0; i--) send_byte(v[i*8 +: 8]);
      chk("fips_out_valid", 128'(out_valid), 128'd1);
      chk("fips_partial", 128'(partial_cnt), 128'd0);
      @(posedge clk); #1;
      chk("fips_valid_pulse", 128'(out_valid), 128'd0);
      chk("fips_blocks_out", 128'(blocks_out), 128'd1);
    end

    // Back-to-back blocks with no bubbles
    do_reset();
    out_ready = 1'b1;
    stalls    = 0;
    exp_q.push_back(BLK_00);
    exp_q.push_back(BLK_10);
    for (int i = 0; i < 32; i++) begin
      send_byte(8'(i));
      if (i == 15 || i == 31) chk("b2b_out_valid", 128'(out_valid), 128'd1);
    end
    chk("b2b_no_stall", 128'(stalls), 128'd0);
    @(posedge clk); #1;
    chk("b2b_blocks_out", 128'(blocks_out), 128'd2);

    // Backpressure: FIFO fills, the 16th byte of the third block waits
    do_reset();
    exp_q.push_back(BLK_00);
    exp_q.push_back(BLK_10);
    exp_q.push_back(BLK_20);
    for (int i = 0; i < 47; i++) send_byte(8'(i));
    chk("bp_partial", 128'(partial_cnt), 128'd15);
    chk("bp_in_ready_low", 128'(in_ready), 128'd0);
    hold_blk  = out_block;
    in_byte   = 8'h2f;
    in_valid  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_hold_partial", 128'(partial_cnt), 128'd15);
    chk("bp_hold_block", out_block, BLK_00);
    chk("bp_block_stable", out_block, hold_blk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_blocks_out1", 128'(blocks_out), 128'd1);
    chk("bp_in_ready_back", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_byte_taken", 128'(partial_cnt), 128'd0);
    chk("bp_head_next", out_block, BLK_10);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_drained", 128'(out_valid), 128'd0);
    chk("bp_blocks_out3", 128'(blocks_out), 128'd3);

    // Clear drops the partial block and the byte offered with it
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    chk("clr_partial5", 128'(partial_cnt), 128'd5);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'h77;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_partial0", 128'(partial_cnt), 128'd0);
    exp_q.push_back(BLK_AA);
    for (int i = 0; i < 16; i++) send_byte(8'hAA + 8'(i));
    chk("clr_out_valid", 128'(out_valid), 128'd1);
    @(posedge clk); #1;
    chk("clr_blocks_out", 128'(blocks_out), 128'd1);

    // Asynchronous reset between clock edges with a stored and a partial block
    do_reset();
    for (int i = 0; i < 23; i++) send_byte(8'(i));
    chk("ar_pre_valid", 128'(out_valid), 128'd1);
    chk("ar_pre_partial", 128'(partial_cnt), 128'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 128'(out_valid), 128'd0);
    chk("ar_out_block", out_block, 128'd0);
    chk("ar_partial", 128'(partial_cnt), 128'd0);
    chk("ar_blocks_out", 128'(blocks_out), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_no_pulse", 128'(out_valid), 128'd0);
    out_ready = 1'b1;
    exp_q.push_back(BLK_C0);
    for (int i = 0; i < 16; i++) send_byte(8'hC0 + 8'(i));
    @(posedge clk); #1;
    chk("ar_clean_blocks", 128'(blocks_out), 128'd1);

    // blocks_out wrap: jump the counter to 0xFFFF, then pop once more
    force dut.pop_cnt = 16'hffff;
    #1 release dut.pop_cnt;
    chk("wrap_preload", 128'(blocks_out), 128'hffff);
    exp_q.push_back(BLK_D0);
    for (int i = 0; i < 16; i++) send_byte(8'hD0 + 8'(i));
    @(posedge clk); #1;
    chk("wrap_blocks_out", 128'(blocks_out), 128'd0);

    repeat (2) @(posedge clk);
    #1 chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
